flash_op_seq: RTL and testbench

FLASH_OP_SEQ -- requirements
Module: flash_op_seq

---
 rtl/flash_op_seq.sv | 147 ++++++++++++++
 tb/tb_flash_op_seq.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_op_seq.sv
// Flash operation sequencer: clears status, issues the two-cycle command, polls the
// status register until ready or the poll limit, then restores read-array mode.
module flash_op_seq #(
  parameter logic [19:0] POLL_MAX = 20'd1000000,
  parameter int unsigned POLL_GAP = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [1:0]  op_code,
  input  logic [24:0] op_addr,
  input  logic [15:0] op_data,
  output logic        done,
  output logic [7:0]  status,
  output logic        err,
  output logic        timeout,
  output logic        wr_en,
  output logic [24:0] wr_addr,
  output logic [15:0] wr_data,
  input  logic        wr_done,
  output logic        rd_en,
  output logic [24:0] rd_addr,
  input  logic [15:0] rd_data,
  input  logic        rd_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_CMD1, S_CMD2, S_POLL_RD, S_POLL_GAP, S_RESTORE, S_DONE
  } state_t;

  // POLL_GAP is expected to be at least 1.
  localparam logic [15:0] GAP_LAST = 16'(POLL_GAP - 1);

  state_t      state, state_n;
  logic        entry;
  logic [1:0]  code_q;
  logic [24:0] addr_q;
  logic [15:0] data_q;
  logic [7:0]  status_q;
  logic        timeout_q;
  logic        rsvd_q;
  logic [19:0] poll_cnt;
  logic [15:0] gap_cnt;
  logic        accept;
  logic        last_poll;
  logic        unused_rd_hi;

  assign accept       = (state == S_IDLE) && op_valid;
  assign last_poll    = (poll_cnt + 20'd1) >= POLL_MAX;
  assign unused_rd_hi = ^rd_data[15:8];

  // State and datapath registers; entry marks the first cycle spent in a state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      entry     <= 1'b0;
      code_q    <= 2'b00;
      addr_q    <= '0;
      data_q    <= '0;
      status_q  <= 8'h00;
      timeout_q <= 1'b0;
      rsvd_q    <= 1'b0;
      poll_cnt  <= '0;
      gap_cnt   <= '0;
    end else begin
      state   <= state_n;
      entry   <= (state_n != state);
      gap_cnt <= (state == S_POLL_GAP) ? gap_cnt + 16'd1 : 16'd0;
      if (accept) begin
        code_q    <= op_code;
        addr_q    <= op_addr;
        data_q    <= op_data;
        status_q  <= 8'h00;
        timeout_q <= 1'b0;
        rsvd_q    <= (op_code == 2'b11);
        poll_cnt  <= '0;
      end
      if ((state == S_POLL_RD) && rd_done) begin
        poll_cnt <= poll_cnt + 20'd1;
        status_q <= rd_data[7:0];
        if (!rd_data[7] && last_poll) begin
          timeout_q <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:     if (op_valid) state_n = (op_code == 2'b11) ? S_DONE : S_CLR;
      S_CLR:      if (wr_done) state_n = S_CMD1;
      S_CMD1:     if (wr_done) state_n = S_CMD2;
      S_CMD2:     if (wr_done) state_n = S_POLL_RD;
      S_POLL_RD:  if (rd_done) state_n = (rd_data[7] || last_poll) ? S_RESTORE : S_POLL_GAP;
      S_POLL_GAP: if (gap_cnt == GAP_LAST) state_n = S_POLL_RD;
      S_RESTORE:  if (wr_done) state_n = S_DONE;
      S_DONE:     state_n = S_IDLE;
      default:    state_n = S_IDLE;
    endcase
  end

  // Bus address/data are only driven while a transfer is outstanding because the mux ORs them.
  always_comb begin
    op_ready = (state == S_IDLE);
    done     = (state == S_DONE);
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    rd_en    = 1'b0;
    rd_addr  = '0;
    case (state)
      S_CLR: begin
        wr_en   = entry;
        wr_addr = addr_q;
        wr_data = 16'h0050;
      end
      S_CMD1: begin
        wr_en   = entry;
        wr_addr = addr_q;
        wr_data = (code_q == 2'b00) ? 16'h0040 :
                  (code_q == 2'b01) ? 16'h0020 : 16'h0060;
      end
      S_CMD2: begin
        wr_en   = entry;
        wr_addr = addr_q;
        wr_data = (code_q == 2'b00) ? data_q : 16'h00D0;
      end
      S_POLL_RD: begin
        rd_en   = entry;
        rd_addr = addr_q;
      end
      S_RESTORE: begin
        wr_en   = entry;
        wr_addr = addr_q;
        wr_data = 16'h00FF;
      end
      default: ;
    endcase
  end

  assign status  = status_q;
  assign timeout = timeout_q;
  assign err     = rsvd_q | status_q[5] | status_q[4] | status_q[3] | status_q[1] | timeout_q;

endmodule

// File: tb/tb_flash_op_seq.sv
// Bench for flash_op_seq: a randomized flash bus responder plus a per-operation
// reference model of the expected write sequence, read count and final status.
module tb_flash_op_seq;

  localparam int PMAX = 4;
  localparam int PGAP = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [1:0]  op_code = 2'b00;
  logic [24:0] op_addr = '0;
  logic [15:0] op_data = '0;
  logic        done;
  logic [7:0]  status;
  logic        err;
  logic        timeout;
  logic        wr_en;
  logic [24:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_done = 1'b0;
  logic        rd_en;
  logic [24:0] rd_addr;
  logic [15:0] rd_data = '0;
  logic        rd_done = 1'b0;

  flash_op_seq #(.POLL_MAX(20'(PMAX)), .POLL_GAP(PGAP)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .op_addr(op_addr), .op_data(op_data),
    .done(done), .status(status), .err(err), .timeout(timeout),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_done(wr_done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_done(rd_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [24:0] wr_log_addr[$];
  logic [15:0] wr_log_data[$];
  logic [24:0] rd_log_addr[$];
  logic [7:0]  stat_q[$];
  logic [7:0]  stat_plan[$];
  int first_wr_cyc = -1;
  int last_rd_done_cyc = 0;
  int rd_done_n = 0;
  int last_acc_cyc = 0;
  int last_done_cyc = 0;
  bit inject_stray = 0;

  bit wr_pend = 0, rd_pend = 0;
  int wr_cnt = 0, rd_cnt = 0;
  logic [24:0] cur_wa, cur_ra;
  logic [15:0] cur_wd;
  logic [7:0]  mon_v;

  // Flash bus responder: random completion latency, status bytes from stat_q, protocol checks.
  always @(negedge clk) begin
    wr_done = 1'b0;
    rd_done = 1'b0;
    rd_data = 16'($urandom);
    if (rst) begin
      wr_pend = 0;
      rd_pend = 0;
    end else begin
      checks++;
      if (wr_en && rd_en) begin
        errors++;
        $display("[TB] FAIL bus_overlap: got wr_en=%b rd_en=%b, required not both", wr_en, rd_en);
      end
      if (wr_pend) begin
        checks++;
        if (wr_en || wr_addr !== cur_wa || wr_data !== cur_wd) begin
          errors++;
          $display("[TB] FAIL wr_hold: got en=%b addr=%h data=%h, required en=0 addr=%h data=%h",
                   wr_en, wr_addr, wr_data, cur_wa, cur_wd);
        end
        wr_cnt--;
        if (wr_cnt == 0) begin
          wr_done = 1'b1;
          wr_pend = 0;
        end
      end else if (wr_en) begin
        if (wr_log_data.size() == 0) first_wr_cyc = cyc;
        wr_log_addr.push_back(wr_addr);
        wr_log_data.push_back(wr_data);
        cur_wa = wr_addr;
        cur_wd = wr_data;
        wr_cnt = $urandom_range(0, 3);
        if (wr_cnt == 0) wr_done = 1'b1;
        else wr_pend = 1;
      end else begin
        checks++;
        if (wr_addr !== '0 || wr_data !== '0) begin
          errors++;
          $display("[TB] FAIL wr_idle_zero: got addr=%h data=%h, required 0", wr_addr, wr_data);
        end
        if (inject_stray && $urandom_range(0, 3) == 0) wr_done = 1'b1;
      end

      if (rd_pend) begin
        checks++;
        if (rd_en || rd_addr !== cur_ra) begin
          errors++;
          $display("[TB] FAIL rd_hold: got en=%b addr=%h, required en=0 addr=%h", rd_en, rd_addr, cur_ra);
        end
        rd_cnt--;
      end else if (rd_en) begin
        if (rd_done_n > 0) begin
          checks++;
          if (cyc !== last_rd_done_cyc + PGAP + 1) begin
            errors++;
            $display("[TB] FAIL rd_spacing: got read at cycle %0d, required %0d", cyc, last_rd_done_cyc + PGAP + 1);
          end
        end
        rd_log_addr.push_back(rd_addr);
        cur_ra = rd_addr;
        rd_cnt = $urandom_range(0, 2);
        rd_pend = 1;
      end else begin
        checks++;
        if (rd_addr !== '0) begin
          errors++;
          $display("[TB] FAIL rd_idle_zero: got addr=%h, required 0", rd_addr);
        end
        if (inject_stray && $urandom_range(0, 3) == 0) rd_done = 1'b1;
      end
      if (rd_pend && rd_cnt == 0) begin
        mon_v = (stat_q.size() > 0) ? stat_q.pop_front() : 8'h00;
        rd_data = {8'($urandom), mon_v};
        rd_done = 1'b1;
        rd_pend = 0;
        last_rd_done_cyc = cyc;
        rd_done_n++;
      end
    end
  end

  // Runs one operation against the reference model; called and returns at a falling edge.
  task automatic run_op(input logic [1:0] code, input logic [24:0] addr,
                        input logic [15:0] data, input bit hold);
    logic [15:0] exp_wd[$];
    int exp_reads;
    logic [7:0] exp_status, v;
    logic exp_to, exp_err;
    int n;
    exp_wd = {};
    exp_reads = 0;
    exp_status = 8'h00;
    exp_to = 1'b0;
    exp_err = 1'b1;
    if (code != 2'b11) begin
      exp_wd.push_back(16'h0050);
      exp_wd.push_back(code == 2'b00 ? 16'h0040 : code == 2'b01 ? 16'h0020 : 16'h0060);
      exp_wd.push_back(code == 2'b00 ? data : 16'h00D0);
      exp_wd.push_back(16'h00FF);
      exp_reads = PMAX;
      exp_to = 1'b1;
      for (int i = 0; i < PMAX; i++) begin
        v = (i < stat_plan.size()) ? stat_plan[i] : 8'h00;
        if (v[7]) begin
          exp_reads = i + 1;
          exp_to = 1'b0;
          break;
        end
      end
      exp_status = (exp_reads - 1 < stat_plan.size()) ? stat_plan[exp_reads - 1] : 8'h00;
      exp_err = exp_to | exp_status[5] | exp_status[4] | exp_status[3] | exp_status[1];
    end
    stat_q = stat_plan;
    wr_log_addr = {};
    wr_log_data = {};
    rd_log_addr = {};
    rd_done_n = 0;
    first_wr_cyc = -1;

    op_code = code;
    op_addr = addr;
    op_data = data;
    op_valid = 1'b1;
    n = 0;
    while (op_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (op_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL accept_wait: got op_ready=%b, required 1", op_ready);
      op_valid = 1'b0;
      return;
    end
    last_acc_cyc = cyc;
    @(negedge clk);
    if (!hold) op_valid = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL done_wait: got done=%b, required 1", done);
      return;
    end
    last_done_cyc = cyc;

    checks++;
    if (code == 2'b11) begin
      if (cyc !== last_acc_cyc + 1) begin
        errors++;
        $display("[TB] FAIL rsvd_latency: got done at %0d, required %0d", cyc, last_acc_cyc + 1);
      end
    end else if (first_wr_cyc !== last_acc_cyc + 1) begin
      errors++;
      $display("[TB] FAIL wr_latency: got first wr_en at %0d, required %0d", first_wr_cyc, last_acc_cyc + 1);
    end
    checks++;
    if (status !== exp_status || err !== exp_err || timeout !== exp_to) begin
      errors++;
      $display("[TB] FAIL result: got status=%h err=%b timeout=%b, required status=%h err=%b timeout=%b",
               status, err, timeout, exp_status, exp_err, exp_to);
    end
    checks++;
    if (wr_log_data.size() !== exp_wd.size()) begin
      errors++;
      $display("[TB] FAIL wr_count: got %0d writes, required %0d", wr_log_data.size(), exp_wd.size());
    end else begin
      for (int i = 0; i < exp_wd.size(); i++) begin
        checks++;
        if (wr_log_data[i] !== exp_wd[i] || wr_log_addr[i] !== addr) begin
          errors++;
          $display("[TB] FAIL wr_seq[%0d]: got %h@%h, required %h@%h",
                   i, wr_log_data[i], wr_log_addr[i], exp_wd[i], addr);
        end
      end
    end
    checks++;
    if (rd_log_addr.size() !== exp_reads) begin
      errors++;
      $display("[TB] FAIL rd_count: got %0d reads, required %0d", rd_log_addr.size(), exp_reads);
    end
    foreach (rd_log_addr[i]) begin
      checks++;
      if (rd_log_addr[i] !== addr) begin
        errors++;
        $display("[TB] FAIL rd_addr[%0d]: got %h, required %h", i, rd_log_addr[i], addr);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || op_ready !== 1'b1 || status !== exp_status || err !== exp_err) begin
      errors++;
      $display("[TB] FAIL after_done: got done=%b op_ready=%b status=%h err=%b, required 0 1 %h %b",
               done, op_ready, status, err, exp_status, exp_err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    op_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({op_ready, done, err, timeout, status, wr_en, rd_en} !== {4'b1000, 8'h00, 2'b00} ||
        wr_addr !== '0 || wr_data !== '0 || rd_addr !== '0) begin
      errors++;
      $display("[TB] FAIL reset_values: got rdy=%b done=%b err=%b to=%b st=%h wr=%b rd=%b wa=%h wd=%h ra=%h, required 1 0 0 0 00 0 0 0 0 0",
               op_ready, done, err, timeout, status, wr_en, rd_en, wr_addr, wr_data, rd_addr);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (op_ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_release: got op_ready=%b done=%b, required 1 0", op_ready, done);
    end
  endtask

  task automatic test_program();
    stat_plan = {8'h00, 8'h00, 8'h80};
    run_op(2'b00, 25'h0000100, 16'hA5A5, 1'b0);
  endtask

  task automatic test_erase();
    stat_plan = {8'hA0};
    run_op(2'b01, 25'h0020000, 16'h1234, 1'b0);
  endtask

  task automatic test_timeout();
    stat_plan = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_op(2'b10, 25'h1ABCDEF, 16'h0000, 1'b0);
  endtask

  task automatic test_reserved();
    stat_plan = {8'h80};
    run_op(2'b11, 25'h0000055, 16'hFFFF, 1'b0);
  endtask

  task automatic test_reset_mid_op();
    int n;
    stat_plan = {8'h42, 8'h42, 8'h42, 8'h42};
    stat_q = stat_plan;
    wr_log_addr = {};
    wr_log_data = {};
    rd_log_addr = {};
    rd_done_n = 0;
    op_code = 2'b00;
    op_addr = 25'h0000321;
    op_data = 16'h5A5A;
    op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    n = 0;
    while (rd_done_n < 1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (op_ready !== 1'b1 || done !== 1'b0 || err !== 1'b0 || timeout !== 1'b0 || status !== 8'h00 ||
        wr_en !== 1'b0 || rd_en !== 1'b0 || wr_addr !== '0 || wr_data !== '0 || rd_addr !== '0) begin
      errors++;
      $display("[TB] FAIL midop_reset: got rdy=%b done=%b err=%b to=%b st=%h wr=%b rd=%b, required 1 0 0 0 00 0 0",
               op_ready, done, err, timeout, status, wr_en, rd_en);
    end
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("[TB] FAIL midop_no_done: got done=%b, required 0", done);
      end
    end
    checks++;
    if (wr_log_data.size() !== 3) begin
      errors++;
      $display("[TB] FAIL midop_no_restore: got %0d writes, required 3", wr_log_data.size());
    end
    stat_plan = {8'h00, 8'h80};
    run_op(2'b10, 25'h0040000, 16'h0000, 1'b0);
  endtask

  task automatic test_back_to_back();
    int prev_done;
    stat_plan = {8'h00, 8'h80};
    run_op(2'b00, 25'h0000200, 16'hC3C3, 1'b1);
    prev_done = last_done_cyc;
    stat_plan = {8'h90};
    run_op(2'b01, 25'h0060000, 16'h0000, 1'b0);
    checks++;
    if (last_acc_cyc !== prev_done + 1) begin
      errors++;
      $display("[TB] FAIL b2b_accept: got accept at %0d, required %0d", last_acc_cyc, prev_done + 1);
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    inject_stray = 1;
    for (int k = 0; k < 10; k++) begin
      stat_plan = {};
      for (int j = 0; j < $urandom_range(1, 6); j++) begin
        b = 8'($urandom);
        if ($urandom_range(0, 2) != 0) b[7] = 1'b0;
        stat_plan.push_back(b);
      end
      run_op(2'($urandom_range(0, 3)), 25'($urandom), 16'($urandom), 1'b0);
    end
    inject_stray = 0;
  endtask

  initial begin
    test_reset();
    test_program();
    test_erase();
    test_timeout();
    test_reserved();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got simulation still running, required completion");
    $fatal(1);
  end

endmodule
